// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bus between the decode/issue logic and pipe_hazard_ctrl.
// The master drives the decoded ID instruction and the EX redirect; the slave returns stall/flush/forward controls.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wr_en;
  logic [4:0]       id_wr_addr;
  logic             id_is_load;
  logic             ex_redirect;

  logic             stall;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             wb_retire;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wr_en, id_wr_addr, id_is_load, ex_redirect,
    input  stall, flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel,
           wb_retire, retire_cnt, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wr_en, id_wr_addr, id_is_load, ex_redirect,
    output stall, flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel,
           wb_retire, retire_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: a shadow scoreboard of EX/MEM/WB
// destinations drives load-use stall, redirect flush, EX forwarding selects and retire/stall counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  // Destination part of a shadow entry; MEM and WB only ever need this plus the MEM load flag.
  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] wa;
  } dest_t;

  typedef struct packed {
    dest_t      dst;
    logic       ld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
  } entry_t;

  function automatic logic hit(input dest_t d, input logic [4:0] src, input logic en);
    return d.v & d.we & (d.wa == src) & (d.wa != 5'd0) & en;
  endfunction

  // MEM is checked first so the youngest producer wins; a load in MEM is never a source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic en,
                                         input dest_t mem, input logic mem_ld, input dest_t wb);
    if (hit(mem, src, en) && !mem_ld) return 2'b10;
    if (hit(wb, src, en))             return 2'b01;
    return 2'b00;
  endfunction

  entry_t           ex_q;
  dest_t            mem_q;
  logic             mem_ld_q;
  dest_t            wb_q;
  entry_t           id_entry;
  entry_t           ex_next;
  logic             stall;
  logic [CNT_W-1:0] retire_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    id_entry        = '0;
    id_entry.dst.v  = bus.id_valid;
    id_entry.dst.we = bus.id_wr_en;
    id_entry.dst.wa = bus.id_wr_addr;
    id_entry.ld     = bus.id_is_load;
    id_entry.rs     = bus.id_rs;
    id_entry.rt     = bus.id_rt;
    id_entry.urs    = bus.id_use_rs;
    id_entry.urt    = bus.id_use_rt;
  end

  assign stall = bus.id_valid & ex_q.ld
               & (hit(ex_q.dst, bus.id_rs, bus.id_use_rs) | hit(ex_q.dst, bus.id_rt, bus.id_use_rt))
               & ~bus.ex_redirect;

  // A stalled or wrong-path ID instruction is replaced by an all-zero bubble.
  assign ex_next = (stall | bus.ex_redirect) ? entry_t'('0) : id_entry;

  // NOTE: sequential state uses non-blocking assignments so WB<-MEM<-EX all sample pre-edge values.
  // NOTE: the whole scoreboard is reset so in-flight entries are dropped and never retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      mem_ld_q     <= 1'b0;
      wb_q         <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      wb_q     <= mem_q;
      mem_q    <= ex_q.dst;
      mem_ld_q <= ex_q.ld;
      ex_q     <= ex_next;
      if (wb_q.v && (retire_cnt_q != {CNT_W{1'b1}}))
        retire_cnt_q <= retire_cnt_q + 1'b1;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.stall       = stall;
  assign bus.flush_if_id = bus.ex_redirect;
  assign bus.flush_id_ex = bus.ex_redirect;
  assign bus.fwd_a_sel   = fwd_sel(ex_q.rs, ex_q.urs, mem_q, mem_ld_q, wb_q);
  assign bus.fwd_b_sel   = fwd_sel(ex_q.rt, ex_q.urt, mem_q, mem_ld_q, wb_q);
  assign bus.wb_retire   = wb_q.v;
  assign bus.retire_cnt  = retire_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
